// File: rtl/peak_detector_if.sv
// Event handshake between the peak detector and its consumer.
// The producer drives the head event and drop count; the consumer drives peak_ready.
interface peak_detector_if #(
    parameter int DW  = 16,
    parameter int TSW = 32
);
    logic [DW-1:0]  peak_amp;
    logic [TSW-1:0] peak_time;
    logic           peak_valid;
    logic           peak_ready;
    logic [7:0]     drop_count;

    modport master (
        output peak_amp,
        output peak_time,
        output peak_valid,
        output drop_count,
        input  peak_ready
    );

    modport slave (
        input  peak_amp,
        input  peak_time,
        input  peak_valid,
        input  drop_count,
        output peak_ready
    );
endinterface

// File: rtl/peak_detector.sv
// Threshold-triggered peak detector with timestamping, holdoff dead time and
// a 2-entry event buffer that drops (and counts) events when full.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a sample above THRESHOLD
// S_ARMED | tracking the running maximum of the current pulse
// S_HOLD  | dead time after an event; input ignored until counter hits 0
module peak_detector #(
    parameter int SIZE_FILTER_DATA = 16,
    parameter int THRESHOLD        = 64,
    parameter int HOLDOFF          = 16,
    parameter int TS_WIDTH         = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SIZE_FILTER_DATA-1:0] input_data_i,
    peak_detector_if.master             pk_if
);
    localparam int DW = SIZE_FILTER_DATA;
    localparam logic [DW-1:0] THRESH  = THRESHOLD[DW-1:0];
    localparam logic [9:0]    HOLD_LD = HOLDOFF[9:0];

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HOLD} state_t;

    state_t              state_q, state_d;
    logic [TS_WIDTH-1:0] ts_q;
    logic [DW-1:0]       max_q, max_d;
    logic [TS_WIDTH-1:0] max_ts_q, max_ts_d;
    logic [9:0]          hold_q, hold_d;
    logic                push;

    logic [DW-1:0]       head_amp_q, head_amp_d, tail_amp_q, tail_amp_d;
    logic [TS_WIDTH-1:0] head_ts_q, head_ts_d, tail_ts_q, tail_ts_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [7:0]          drop_q, drop_d;
    logic                pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ts_q     <= '0;
            max_q    <= '0;
            max_ts_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            ts_q     <= ts_q + TS_WIDTH'(1);
            max_q    <= max_d;
            max_ts_q <= max_ts_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        max_d    = max_q;
        max_ts_d = max_ts_q;
        hold_d   = hold_q;
        push     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (input_data_i > THRESH) begin
                    state_d  = S_ARMED;
                    max_d    = input_data_i;
                    max_ts_d = ts_q;
                end
            end
            S_ARMED: begin
                if (input_data_i > THRESH) begin
                    // strict compare keeps the earliest timestamp on ties
                    if (input_data_i > max_q) begin
                        max_d    = input_data_i;
                        max_ts_d = ts_q;
                    end
                end else begin
                    push    = 1'b1;
                    hold_d  = HOLD_LD;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_q == 10'd0) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - 10'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pop = (cnt_q != 2'd0) && pk_if.peak_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_amp_q <= '0;
            head_ts_q  <= '0;
            tail_amp_q <= '0;
            tail_ts_q  <= '0;
            cnt_q      <= '0;
            drop_q     <= '0;
        end else begin
            head_amp_q <= head_amp_d;
            head_ts_q  <= head_ts_d;
            tail_amp_q <= tail_amp_d;
            tail_ts_q  <= tail_ts_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        head_amp_d = head_amp_q;
        head_ts_d  = head_ts_q;
        tail_amp_d = tail_amp_q;
        tail_ts_d  = tail_ts_q;
        cnt_d      = cnt_q;
        drop_d     = drop_q;
        if (push && pop) begin
            if (cnt_q == 2'd1) begin
                head_amp_d = max_q;
                head_ts_d  = max_ts_q;
            end else begin
                head_amp_d = tail_amp_q;
                head_ts_d  = tail_ts_q;
                tail_amp_d = max_q;
                tail_ts_d  = max_ts_q;
            end
        end else if (push) begin
            if (cnt_q == 2'd0) begin
                head_amp_d = max_q;
                head_ts_d  = max_ts_q;
                cnt_d      = 2'd1;
            end else if (cnt_q == 2'd1) begin
                tail_amp_d = max_q;
                tail_ts_d  = max_ts_q;
                cnt_d      = 2'd2;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (pop) begin
            head_amp_d = tail_amp_q;
            head_ts_d  = tail_ts_q;
            cnt_d      = cnt_q - 2'd1;
        end
    end

    assign pk_if.peak_valid = (cnt_q != 2'd0);
    assign pk_if.peak_amp   = pk_if.peak_valid ? head_amp_q : '0;
    assign pk_if.peak_time  = pk_if.peak_valid ? head_ts_q  : '0;
    assign pk_if.drop_count = drop_q;
endmodule

// File: tb/tb_peak_detector.sv
// Bench for peak_detector: timestamp-based event model checked every cycle,
// plus directed pulses with literal expected results.
module tb_peak_detector;
    localparam int DW = 16, TSW = 32, TH = 64, HO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] input_data = '0;

    peak_detector_if #(.DW(DW), .TSW(TSW)) pk_if();

    peak_detector #(
        .SIZE_FILTER_DATA(DW), .THRESHOLD(TH), .HOLDOFF(HO), .TS_WIDTH(TSW)
    ) dut (
        .clk(clk), .reset(reset), .input_data_i(input_data), .pk_if(pk_if)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr = 0;

    task automatic chk(string name, longint act, longint exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: an event is the max of a run of above-threshold samples; after the
    // falling sample at ts t, samples with ts <= t+HOLDOFF+1 are ignored.
    longint m_ts = 0, m_dead_end = -1, m_maxts = 0;
    bit     m_armed = 0;
    int     m_max = 0, m_drop = 0;
    int     q_amp[$];
    longint q_ts[$];

    always @(posedge clk or posedge reset) begin
        bit pop, push;
        int s;
        if (reset) begin
            m_ts = 0; m_dead_end = -1; m_armed = 0; m_max = 0; m_maxts = 0; m_drop = 0;
            q_amp.delete(); q_ts.delete();
        end else begin
            s = int'(input_data);
            pop = (q_amp.size() > 0) && pk_if.peak_ready;
            push = 0;
            if (m_ts > m_dead_end) begin
                if (!m_armed) begin
                    if (s > TH) begin m_armed = 1; m_max = s; m_maxts = m_ts; end
                end else if (s > TH) begin
                    if (s > m_max) begin m_max = s; m_maxts = m_ts; end
                end else begin
                    push = 1; m_armed = 0; m_dead_end = m_ts + HO + 1;
                end
            end
            if (pop) begin q_amp.delete(0); q_ts.delete(0); end
            if (push) begin
                if (q_amp.size() < 2) begin q_amp.push_back(m_max); q_ts.push_back(m_maxts); end
                else if (m_drop < 255) m_drop++;
            end
            m_ts++;
        end
    end

    always @(negedge clk) begin
        chk("cyc_valid", longint'(pk_if.peak_valid), longint'(q_amp.size() > 0));
        chk("cyc_amp",   longint'(pk_if.peak_amp),   (q_amp.size() > 0) ? longint'(q_amp[0]) : 0);
        chk("cyc_time",  longint'(pk_if.peak_time),  (q_ts.size() > 0) ? q_ts[0] : 0);
        chk("cyc_drop",  longint'(pk_if.drop_count), longint'(m_drop));
    end

    task automatic step(int s);
        input_data = DW'(s);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        input_data = DW'(500);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic pre_events(); // events A(100@0), B(150@7), then 250@14 armed
        step(100); step(10);
        repeat (5) step(0);
        step(150); step(10);
        repeat (5) step(0);
        step(250);
    endtask

    initial begin
        pk_if.peak_ready = 1'b1;
        reset = 1'b1;
        input_data = DW'(500);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", longint'(pk_if.peak_valid), 0);
        chk("rst_amp",   longint'(pk_if.peak_amp),   0);
        chk("rst_time",  longint'(pk_if.peak_time),  0);
        chk("rst_drop",  longint'(pk_if.drop_count), 0);
        reset = 1'b0;

        // basic pulse
        step(0); step(0); step(100); step(200); step(150); step(50);
        chk("t1_valid", longint'(pk_if.peak_valid), 1);
        chk("t1_amp",   longint'(pk_if.peak_amp),   200);
        chk("t1_time",  longint'(pk_if.peak_time),  3);
        step(0);
        chk("t1_popped", longint'(pk_if.peak_valid), 0);

        // equal samples keep earliest timestamp
        do_reset();
        step(100); step(200); step(200); step(10);
        chk("t2_amp",  longint'(pk_if.peak_amp),  200);
        chk("t2_time", longint'(pk_if.peak_time), 1);

        // holdoff ignores the 300s and the exit-edge sample
        do_reset();
        step(0); step(100); step(150); step(100); step(80); step(30);
        chk("t3_ev1_amp",  longint'(pk_if.peak_amp),  150);
        chk("t3_ev1_time", longint'(pk_if.peak_time), 2);
        repeat (4) step(300);
        step(40);
        chk("t3_no_ev_a", longint'(pk_if.peak_valid), 0);
        step(120);
        chk("t3_no_ev_b", longint'(pk_if.peak_valid), 0);
        step(40);
        chk("t3_ev2_amp",  longint'(pk_if.peak_amp),  120);
        chk("t3_ev2_time", longint'(pk_if.peak_time), 11);

        // full buffer drops the third event
        do_reset();
        pk_if.peak_ready = 1'b0;
        pre_events();
        step(10);
        repeat (3) step(0);
        chk("t4_drop",    longint'(pk_if.drop_count), 1);
        chk("t4_head",    longint'(pk_if.peak_amp),   100);
        chk("t4_stable",  longint'(pk_if.peak_time),  0);
        pk_if.peak_ready = 1'b1;
        step(0);
        chk("t4_second",  longint'(pk_if.peak_amp),   150);
        chk("t4_sec_ts",  longint'(pk_if.peak_time),  7);
        step(0);
        chk("t4_empty",   longint'(pk_if.peak_valid), 0);
        chk("t4_drop_kept", longint'(pk_if.drop_count), 1);

        // push and pop on the same edge while full: no drop
        do_reset();
        pk_if.peak_ready = 1'b0;
        pre_events();
        pk_if.peak_ready = 1'b1;
        step(10);
        chk("t6_drop", longint'(pk_if.drop_count), 0);
        chk("t6_head", longint'(pk_if.peak_amp),   150);
        step(0);
        chk("t6_third_amp",  longint'(pk_if.peak_amp),  250);
        chk("t6_third_time", longint'(pk_if.peak_time), 14);
        step(0);
        chk("t6_empty", longint'(pk_if.peak_valid), 0);

        // reset mid-event abandons it; ts restarts at 0
        do_reset();
        step(0); step(100); step(180);
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", longint'(pk_if.peak_valid), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        step(0);
        chk("t5_no_ev_a", longint'(pk_if.peak_valid), 0);
        step(90);
        chk("t5_no_ev_b", longint'(pk_if.peak_valid), 0);
        step(50);
        chk("t5_amp",  longint'(pk_if.peak_amp),  90);
        chk("t5_time", longint'(pk_if.peak_time), 1);
        step(0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule

// File: doc/peak_detector.md
PEAK_DETECTOR -- requirements
Module: peak_detector

Interface
REQ-001 Parameter THRESHOLD, default 64, trigger level in filter-output units (unsigned, SIZE_FILTER_DATA bits).
REQ-002 Parameter HOLDOFF, default 16, dead-time cycles after each event, range 0..1023.
REQ-003 Parameter TS_WIDTH, default 32, timestamp counter width.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state.
REQ-006 input_data  input  SIZE_FILTER_DATA  shaped filter output, one unsigned sample per clock, no valid qualifier.
REQ-007 peak_amp  output  SIZE_FILTER_DATA  amplitude of the head event.
REQ-008 peak_time  output  TS_WIDTH  timestamp of the head event's maximum.
REQ-009 peak_valid  output  1  head event present.
REQ-010 peak_ready  input  1  consumer accepts the head event.
REQ-011 drop_count  output  8  events lost to a full buffer, saturating.

Function
REQ-012 Timestamp counter ts SHALL be 0 at the first edge after reset release, increment by 1 per edge, and wrap modulo 2^TS_WIDTH.
REQ-013 The sample present before edge t SHALL be processed at edge t and tagged with the current ts.
REQ-014 States: IDLE, ARMED, HOLD.
REQ-015 IDLE: sample > THRESHOLD -> ARMED; max <= sample; max_ts <= ts. Otherwise stay IDLE.
REQ-016 ARMED, sample > THRESHOLD: if sample > max, update max and max_ts; equal samples SHALL keep the earlier max_ts.
REQ-017 ARMED, sample <= THRESHOLD: push (max, max_ts) into the output buffer; load holdoff counter with HOLDOFF; -> HOLD.
REQ-018 HOLD: ignore input; decrement counter each edge; at 0 -> IDLE. HOLDOFF=0 SHALL return to IDLE on the next edge.
REQ-019 A sample above THRESHOLD on the edge HOLD exits SHALL NOT arm; arming resumes only from IDLE.
REQ-020 Output buffer: 2-entry FIFO, in order; head drives peak_amp/peak_time; peak_valid = not empty.
REQ-021 Pop SHALL occur at an edge with peak_valid && peak_ready; head outputs SHALL hold stable while peak_valid && !peak_ready.
REQ-022 Latency: event pushed into an empty FIFO at edge t SHALL show peak_valid=1 after edge t (one-cycle latency from the below-threshold sample).
REQ-023 Push into a full FIFO with no simultaneous pop SHALL discard the new event and increment drop_count, saturating at 255.
REQ-024 Push and pop at the same edge with the FIFO full SHALL accept the push with no drop.
REQ-025 peak_amp/peak_time SHALL read 0 when peak_valid=0.
REQ-026 Amplitude comparisons SHALL be unsigned, full width, with no truncation.

Reset
REQ-027 Reset assertion SHALL immediately force state IDLE, ts=0, max=0, holdoff counter=0, FIFO empty, peak_valid=0, peak_amp=0, peak_time=0, drop_count=0.
REQ-028 Reset mid-event SHALL abandon the event without pushing it; queued events SHALL be lost.
REQ-029 drop_count SHALL clear only on reset.

Verification (THRESHOLD=64, HOLDOFF=4, peak_ready=1 unless stated)
REQ-030 Assert reset, apply data 500 -> all outputs 0, state IDLE; release -> first sample gets ts=0.
REQ-031 Samples 0,0,100,200,150,50 at ts 0..5 -> peak_valid high for one cycle after edge 5, peak_amp=200, peak_time=3.
REQ-032 Samples 100,200,200,10 at ts 0..3 -> peak_amp=200, peak_time=1.
REQ-033 Pulse ends at ts 5; samples 300 at ts 6..9, then 40, then 120,40 -> the 300s are ignored; second event amp 120.
REQ-034 peak_ready=0, three separated events (amps 100, 150, 250) -> drop_count=1; on raising peak_ready, 100 pops, then 150; 250 is never output.
REQ-035 Reset asserted while ARMED with max=180 -> no event output after release; a fresh pulse of peak 90 reports amp 90 with a ts counted from 0.
